// File: rtl/segasys1_pkg.sv
// Shared constants and types for the System 1 main-board work-RAM arbiter.
// Holds the arbiter state encoding and the default timing constants.
package segasys1_pkg;

    localparam int WRAM_AW          = 12;
    localparam int WAIT_MAX_DEF     = 64;
    localparam int PAUSE_SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HS_DATA = 2'd1,
        HS_ACK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/segasys1_wram_arb.sv
// Work-RAM port arbiter: the Z80 always wins, hiscore traffic fills idle cycles,
// and a starved hiscore request freezes the CPU and then steals the port.
module segasys1_wram_arb
    import segasys1_pkg::*;
#(
    parameter int AW           = WRAM_AW,
    parameter int WAIT_MAX     = WAIT_MAX_DEF,
    parameter int PAUSE_SETTLE = PAUSE_SETTLE_DEF
) (
    input  logic          clk48M,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ad,
    input  logic          cpu_cs,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_dw,
    output logic [7:0]    cpu_dr,
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_din,
    output logic [7:0]    hs_dout,
    output logic          hs_ack,
    output logic          cpu_pause,
    output logic [AW-1:0] ram_a,
    output logic          ram_we,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q
);

    localparam logic [7:0] C_WAIT_MAX  = 8'(WAIT_MAX);
    localparam logic [7:0] C_WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [3:0] C_SETTLE    = 4'(PAUSE_SETTLE);

    arb_state_t  r_state;
    logic [7:0]  r_cpu_dr;
    logic [7:0]  r_hs_dout;
    logic        r_cpu_pause;
    logic [7:0]  r_wait_cnt;
    logic [3:0]  r_settle_cnt;
    logic        r_cpu_owned_d;
    logic        r_hs_we;

    logic        w_steal;
    logic        w_issue;
    logic        w_starve;

    always_comb begin
        w_steal  = r_cpu_pause && (r_settle_cnt == C_SETTLE);
        w_issue  = (r_state == IDLE) && hs_req && (!cpu_cs || w_steal);
        // A starved cycle is one where the request waits only because the CPU holds the bus.
        w_starve = (r_state == IDLE) && hs_req && cpu_cs && !w_steal;
    end

    always_comb begin
        ram_a  = cpu_ad;
        ram_d  = cpu_dw;
        ram_we = cpu_cs && cpu_wr;
        if (w_issue) begin
            ram_a  = hs_addr;
            ram_d  = hs_din;
            ram_we = hs_we;
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cpu_dr      <= 8'h00;
            r_hs_dout     <= 8'h00;
            r_cpu_owned_d <= 1'b1;
            r_hs_we       <= 1'b0;
        end else begin
            // ram_q belongs to whoever drove ram_a on the previous cycle.
            r_cpu_owned_d <= !w_issue;
            if (r_cpu_owned_d) begin
                r_cpu_dr <= ram_q;
            end
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= HS_DATA;
                        r_hs_we <= hs_we;
                    end
                end
                HS_DATA: begin
                    if (!r_hs_we) begin
                        r_hs_dout <= ram_q;
                    end
                    r_state <= HS_ACK;
                end
                HS_ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_cpu_pause  <= 1'b0;
            r_wait_cnt   <= 8'h00;
            r_settle_cnt <= 4'h0;
        end else if ((r_state == HS_ACK) || ((r_state == IDLE) && !hs_req)) begin
            r_cpu_pause  <= 1'b0;
            r_wait_cnt   <= 8'h00;
            r_settle_cnt <= 4'h0;
        end else begin
            if (w_issue) begin
                r_wait_cnt <= 8'h00;
            end else if (w_starve && (r_wait_cnt != C_WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 8'h01;
            end
            if (w_starve && (r_wait_cnt >= C_WAIT_LAST)) begin
                r_cpu_pause <= 1'b1;
            end
            // The freeze needs time to reach the CPU before the port can be taken.
            if (r_cpu_pause && (r_settle_cnt != C_SETTLE)) begin
                r_settle_cnt <= r_settle_cnt + 4'h1;
            end
        end
    end

    assign cpu_dr    = r_cpu_dr;
    assign hs_dout   = r_hs_dout;
    assign hs_ack    = (r_state == HS_ACK);
    assign cpu_pause = r_cpu_pause;

endmodule

// File: tb/tb_segasys1_wram_arb.sv
// Self-checking bench for segasys1_wram_arb: directed scenarios plus randomized
// CPU/hiscore traffic, checked every cycle against a shadow-memory model.
module tb_segasys1_wram_arb;

    localparam int TW = 4;
    localparam int TP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] cpu_ad = '0;
    logic        cpu_cs = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dw = '0;
    logic [7:0]  cpu_dr;
    logic        hs_req = 1'b0;
    logic        hs_we = 1'b0;
    logic [11:0] hs_addr = '0;
    logic [7:0]  hs_din = '0;
    logic [7:0]  hs_dout;
    logic        hs_ack;
    logic        cpu_pause;
    logic [11:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = 8'h00;

    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    logic [7:0]  shadow [0:4095] = '{default: 8'h00};
    logic [7:0]  exp_dr [int];
    logic [7:0]  exp_hs_dout = 8'h00;
    bit          rst_prev = 1'b0;
    bit          pl_pending = 1'b0;
    logic [11:0] pl_a_q = '0;
    logic [7:0]  pl_d_q = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    segasys1_wram_arb #(.AW(12), .WAIT_MAX(TW), .PAUSE_SETTLE(TP)) dut (
        .clk48M(clk), .reset(reset),
        .cpu_ad(cpu_ad), .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_dw(cpu_dw), .cpu_dr(cpu_dr),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din),
        .hs_dout(hs_dout), .hs_ack(hs_ack), .cpu_pause(cpu_pause),
        .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write, plus a bench preload port.
    always @(posedge clk) begin
        ram_q <= mem[ram_a];
        if (ram_we) mem[ram_a] <= ram_d;
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_pending = 1'b1;
        pl_a_q = a;
        pl_d_q = d;
    endtask

    // One clock cycle: drive inputs, advance the model, check outputs mid-cycle.
    task automatic cyc_drive(input logic rst_i, input logic cs, input logic wr,
                             input logic [11:0] ad, input logic [7:0] dw,
                             input logic req, input logic we, input logic [11:0] haddr,
                             input logic [7:0] hdin,
                             input bit e_issue, input bit e_ack, input bit e_pause);
        int j;
        bit have_dr;
        logic [7:0] dr_e;
        logic e_we;
        logic [11:0] e_a;
        logic [7:0] e_d;
        @(posedge clk); #1;
        reset = rst_i; cpu_cs = cs; cpu_wr = wr; cpu_ad = ad; cpu_dw = dw;
        hs_req = req; hs_we = we; hs_addr = haddr; hs_din = hdin;
        pl_en = pl_pending; pl_addr = pl_a_q; pl_data = pl_d_q;
        cyc++;
        j = cyc;
        have_dr = exp_dr.exists(j);
        dr_e = have_dr ? exp_dr[j] : 8'h00;
        if (have_dr) exp_dr.delete(j);
        e_a  = e_issue ? haddr : ad;
        e_we = e_issue ? we : (cs & wr);
        e_d  = e_issue ? hdin : dw;
        if (rst_i) begin
            exp_dr.delete();
            exp_dr[j+1] = 8'h00;
            exp_hs_dout = 8'h00;
        end else if (!e_issue) begin
            exp_dr[j+2] = shadow[ad];
        end else if (exp_dr.exists(j+1)) begin
            exp_dr[j+2] = exp_dr[j+1];
        end
        if (e_issue && !we) exp_hs_dout = shadow[haddr];
        if (e_issue && we) shadow[haddr] = hdin;
        else if (!e_issue && cs && wr) shadow[ad] = dw;
        if (pl_pending) shadow[pl_a_q] = pl_d_q;
        pl_pending = 1'b0;
        @(negedge clk);
        chk("ram_a", 32'(ram_a), 32'(e_a));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (e_we) chk("ram_d", 32'(ram_d), 32'(e_d));
        chk("hs_ack", 32'(hs_ack), 32'(e_ack));
        chk("cpu_pause", 32'(cpu_pause), 32'(e_pause));
        if (have_dr) chk("cpu_dr", 32'(cpu_dr), 32'(dr_e));
        if (e_ack || rst_prev) chk("hs_dout", 32'(hs_dout), 32'(exp_hs_dout));
        rst_prev = rst_i;
    endtask

    task automatic cpu_cycle(input logic cs, input logic wr, input logic [11:0] ad,
                             input logic [7:0] dw);
        cyc_drive(1'b0, cs, wr, ad, dw, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // nb = leading cycles with cpu_cs high (nb < 0: random bus activity each cycle).
    // The access issues at the first idle CPU cycle, or is forced after TW+TP starved cycles.
    task automatic hs_txn(input logic [11:0] addr, input logic we, input logic [7:0] din,
                          input int nb, input logic [11:0] ad, input bit drop);
        bit cs_pat [0:TW+TP+2];
        int k;
        logic [11:0] lad;
        for (int o = 0; o <= TW + TP + 2; o++)
            cs_pat[o] = (nb < 0) ? ($urandom_range(3) != 0) : (o < nb);
        k = TW + TP;
        for (int o = TW + TP; o >= 0; o--)
            if (!cs_pat[o]) k = o;
        for (int o = 0; o <= k + 2; o++) begin
            lad = (nb < 0) ? 12'($urandom_range(0, 63)) : ad;
            cyc_drive(1'b0, cs_pat[o], 1'b0, lad, 8'h00, !(drop && (o > k)), we, addr, din,
                      o == k, o == k + 2, (k >= TW) && (o >= TW));
        end
        if (we) chk("ram_content", 32'(mem[addr]), 32'(din));
        $display("txn addr=%03h we=%0d din=%02h issue_offset=%0d ack_cycle=%0d hs_dout=%02h",
                 addr, we, din, k, cyc, hs_dout);
    endtask

    initial begin
        logic [7:0] v1, v2;
        int sel, nb;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        exp_dr.delete();
        exp_dr[cyc+1] = 8'h00;
        exp_hs_dout = 8'h00;
        rst_prev = 1'b1;

        // CPU-only traffic: read latency and write-through
        for (int i = 0; i < 40; i++)
            cpu_cycle(1'($urandom_range(1)), 1'($urandom_range(1)),
                      12'($urandom_range(0, 15)), 8'($urandom));

        // Hiscore read with CPU idle; request dropped right after issue
        preload(12'h123, 8'hA5);
        cpu_cycle(1'b0, 1'b0, 12'h000, 8'h00);
        hs_txn(12'h123, 1'b0, 8'h00, 0, 12'h000, 1'b1);
        chk("hs_read_a5", 32'(hs_dout), 32'h0000_00A5);
        cpu_cycle(1'b0, 1'b0, 12'h000, 8'h00);

        // CPU priority: write waits behind a CPU burst shorter than the starvation limit
        hs_txn(12'h020, 1'b1, 8'h5A, TW - 1, 12'h010, 1'b0);
        cpu_cycle(1'b0, 1'b0, 12'h020, 8'h00);

        // Starvation: CPU never releases, forced steal after TW+TP cycles
        preload(12'h7FF, 8'($urandom_range(1, 255)));
        cpu_cycle(1'b0, 1'b0, 12'h055, 8'h00);
        preload(12'h055, 8'($urandom_range(1, 255)));
        repeat (3) cpu_cycle(1'b0, 1'b0, 12'h055, 8'h00);
        hs_txn(12'h7FF, 1'b0, 8'h00, 100, 12'h055, 1'b0);
        cpu_cycle(1'b1, 1'b0, 12'h055, 8'h00);

        // Withdrawal: request drops before issue, then a fresh request starts from zero
        for (int i = 0; i < TW - 1; i++)
            cyc_drive(1'b0, 1'b1, 1'b0, 12'h055, 8'h00, 1'b1, 1'b0, 12'h0AA, 8'h00,
                      1'b0, 1'b0, 1'b0);
        cpu_cycle(1'b1, 1'b0, 12'h055, 8'h00);
        hs_txn(12'h0AA, 1'b0, 8'h00, 100, 12'h055, 1'b0);
        cpu_cycle(1'b0, 1'b0, 12'h055, 8'h00);

        // Back-to-back reads: request held high across the first ack
        v1 = 8'($urandom_range(1, 127));
        v2 = 8'($urandom_range(128, 255));
        preload(12'h001, v1);
        cpu_cycle(1'b0, 1'b0, 12'h000, 8'h00);
        preload(12'h002, v2);
        cpu_cycle(1'b0, 1'b0, 12'h000, 8'h00);
        hs_txn(12'h001, 1'b0, 8'h00, 0, 12'h000, 1'b0);
        chk("b2b_first", 32'(hs_dout), 32'(v1));
        hs_txn(12'h002, 1'b0, 8'h00, 0, 12'h000, 1'b0);
        chk("b2b_second", 32'(hs_dout), 32'(v2));
        cpu_cycle(1'b0, 1'b0, 12'h055, 8'h00);

        // Reset during HS_DATA of a forced steal
        preload(12'h300, 8'h3C);
        repeat (2) cpu_cycle(1'b0, 1'b0, 12'h055, 8'h00);
        for (int o = 0; o <= TW + TP; o++)
            cyc_drive(1'b0, 1'b1, 1'b0, 12'h055, 8'h00, 1'b1, 1'b0, 12'h300, 8'h00,
                      o == TW + TP, 1'b0, o >= TW);
        cyc_drive(1'b1, 1'b1, 1'b0, 12'h055, 8'h00, 1'b1, 1'b0, 12'h300, 8'h00,
                  1'b0, 1'b0, 1'b1);
        repeat (4) cpu_cycle(1'b0, 1'b0, 12'h055, 8'h00);

        // Randomized mixed traffic
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                1:       nb = 100;
                2:       nb = $urandom_range(0, TW + TP + 1);
                default: nb = -1;
            endcase
            hs_txn(12'($urandom_range(0, 63)), 1'($urandom_range(1)), 8'($urandom),
                   nb, 12'($urandom_range(0, 63)), 1'($urandom_range(1)));
            for (int g = $urandom_range(0, 2); g > 0; g--)
                cpu_cycle(1'($urandom_range(1)), 1'($urandom_range(1)),
                          12'($urandom_range(0, 63)), 8'($urandom));
        end
        repeat (3) cpu_cycle(1'b0, 1'b0, 12'h000, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
